// File: rtl/star_grill_ctrl_multi.sv
// star_grill_ctrl_multi: grill + N star actuator sequencer with watchdog and latched FAULT.
// Optional STAR_STAGGER_EN staggers per-channel star drive start by STAGGER_CYCLES.
module star_grill_ctrl_multi #(
  parameter int N_STARS        = 4,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int STAGGER_CYCLES = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_press,
  input  logic                   i_pull,
  input  logic                   i_fault_clr,
  input  logic [1:0]             i_grill_pos,
  input  logic [2*N_STARS-1:0]   i_star_pos,
  output logic                   o_grill_open,
  output logic                   o_grill_close,
  output logic [N_STARS-1:0]     o_star_hide,
  output logic [N_STARS-1:0]     o_star_raise,
  output logic [3:0]             o_state,
  output logic                   o_fault
);
  typedef enum logic [3:0] {
    INIT = 4'd0, CLOSED_UP = 4'd1, G_OPENING = 4'd2, G_CLOSING = 4'd3, G_STOP = 4'd4,
    OPEN_UP = 4'd5, S_HIDING = 4'd6, S_RAISING = 4'd7, S_STOP = 4'd8, OPEN_HIDDEN = 4'd9,
    FAULT = 4'd15
  } state_t;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX  = WW'(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic [WW-1:0] wd_q, wd_d;
  logic grill_open_q, grill_open_d, grill_close_q, grill_close_d, fault_q, fault_d;
  logic [N_STARS-1:0] hide_q, hide_d, raise_q, raise_d, gate, s_up, s_hid, s_err;
  logic fwd, rev, sens_err, all_up, all_hid, g_open, motion, in_open, timeout;
  always_comb begin
    for (int i = 0; i < N_STARS; i++) begin
      s_up[i]  = i_star_pos[2*i +: 2] == 2'b00;
      s_hid[i] = i_star_pos[2*i +: 2] == 2'b01;
      s_err[i] = i_star_pos[2*i +: 2] == 2'b11;
    end
  end
  assign fwd      = i_pull & ~i_press;
  assign rev      = i_press & ~i_pull;
  assign all_up   = &s_up;
  assign all_hid  = &s_hid;
  assign g_open   = i_grill_pos == 2'b01;
  assign sens_err = (i_grill_pos == 2'b11) | (|s_err);
  assign motion   = state_q inside {G_OPENING, G_CLOSING, S_HIDING, S_RAISING};
  assign in_open  = state_q inside {OPEN_UP, S_HIDING, S_RAISING, S_STOP, OPEN_HIDDEN};
  // the motion's TIMEOUT_CYCLES-th cycle is the last one allowed
  assign timeout  = motion && wd_q >= WD_LAST;
  always_comb begin
    state_d = state_q;
    if (sens_err || timeout || (in_open && !g_open)) state_d = FAULT;
    else
      case (state_q)
        INIT:        state_d = !all_up ? (g_open ? (all_hid ? OPEN_HIDDEN : S_STOP) : FAULT)
                             : i_grill_pos == 2'b00 ? CLOSED_UP
                             : i_grill_pos == 2'b10 ? G_STOP : OPEN_UP;
        CLOSED_UP:   state_d = fwd ? G_OPENING : state_q;
        G_OPENING:   state_d = g_open ? OPEN_UP : !fwd ? G_STOP : state_q;
        G_CLOSING:   state_d = i_grill_pos == 2'b00 ? CLOSED_UP : !rev ? G_STOP : state_q;
        G_STOP:      state_d = fwd ? G_OPENING : rev ? G_CLOSING : state_q;
        OPEN_UP:     state_d = fwd ? S_HIDING : rev ? G_CLOSING : state_q;
        S_HIDING:    state_d = all_hid ? OPEN_HIDDEN : !fwd ? S_STOP : state_q;
        S_RAISING:   state_d = all_up ? OPEN_UP : !rev ? S_STOP : state_q;
        S_STOP:      state_d = fwd ? S_HIDING : rev ? S_RAISING : state_q;
        OPEN_HIDDEN: state_d = rev ? S_RAISING : state_q;
        FAULT:       state_d = (i_fault_clr && !i_press && !i_pull) ? INIT : state_q;
        default:     state_d = INIT;
      endcase
  end
  assign wd_d = (state_d != state_q) ? '0 : !motion ? wd_q : (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
`ifdef STAR_STAGGER_EN
  localparam int SMAX = (N_STARS - 1) * STAGGER_CYCLES;
  localparam int SW   = $clog2(SMAX + 2);
  logic [SW-1:0] stg_q, stg_d;
  assign stg_d = (state_d != state_q) ? '0 : (stg_q == SW'(SMAX)) ? stg_q : stg_q + 1'b1;
  always_comb begin
    for (int i = 0; i < N_STARS; i++) gate[i] = stg_d >= SW'(i * STAGGER_CYCLES);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stg_q <= '0;
    else stg_q <= stg_d;
  end
`else
  assign gate = {N_STARS{STAGGER_CYCLES >= 0}};
`endif
  always_comb begin
    grill_open_d  = state_d == G_OPENING && all_up;
    grill_close_d = state_d == G_CLOSING && all_up;
    fault_d       = state_d == FAULT;
    for (int i = 0; i < N_STARS; i++) begin
      hide_d[i]  = state_d == S_HIDING && g_open && !s_hid[i] && gate[i];
      raise_d[i] = state_d == S_RAISING && g_open && !s_up[i] && gate[i];
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= INIT;
      wd_q          <= '0;
      grill_open_q  <= 1'b0;
      grill_close_q <= 1'b0;
      hide_q        <= '0;
      raise_q       <= '0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wd_q          <= wd_d;
      grill_open_q  <= grill_open_d;
      grill_close_q <= grill_close_d;
      hide_q        <= hide_d;
      raise_q       <= raise_d;
      fault_q       <= fault_d;
    end
  end
  assign o_state       = state_q;
  assign o_grill_open  = grill_open_q;
  assign o_grill_close = grill_close_q;
  assign o_star_hide   = hide_q;
  assign o_star_raise  = raise_q;
  assign o_fault       = fault_q;
endmodule
